a2d_intf: RTL and testbench
===========================

A2D_INTF -- requirements
Module: a2d_intf

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all flops on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset; asynchronous and active-low.
REQ-003 SHALL have: strt_cnv  in  1  one-clk pulse requesting a conversion.
REQ-004 SHALL have: chnnl  in  3  ADC channel to convert, sampled with strt_cnv.
REQ-005 SHALL have: cnv_cmplt  out  1  high when res is valid; held until next accepted strt_cnv.
REQ-006 SHALL have: res  out  12  conversion result of the last completed conversion.
REQ-007 SHALL have: a2d_SS_n  out  1  SPI slave select, active-low.
REQ-008 SHALL have: SCLK  out  1  SPI clock, clk/32, idle high.
REQ-009 SHALL have: MOSI  out  1  SPI data to ADC, MSB first.
REQ-010 SHALL have: MISO  in  1  SPI data from ADC.

Function
REQ-011 SHALL implement states IDLE, FRM1, GAP, FRM2; IDLE->FRM1 on strt_cnv, FRM1->GAP at frame end, GAP->FRM2 after 32 clks, FRM2->IDLE at frame end.
REQ-012 SHALL ignore strt_cnv outside IDLE; chnnl SHALL be latched only when strt_cnv is accepted.
REQ-013 Accepted strt_cnv at cycle 0 SHALL clear cnv_cmplt at cycle 1.
REQ-014 Timing from accept (cycle 0): SS_n low cycles 1-520, high 521-552, low 553-1072; SS_n high and cnv_cmplt high at cycle 1073.
REQ-015 SCLK SHALL be MSB of 5-bit divider; divider loaded 5'b10111 on first cycle of each frame, then increments each clk.
REQ-016 Each frame SHALL contain exactly 16 SCLK rising edges (divider 01111->10000); first rise 25 clks after SS_n falls, then every 32 clks.
REQ-017 After 16th rise SCLK SHALL remain high; frame ends when divider reaches 5'b11110; SCLK SHALL be high whenever SS_n is high.
REQ-018 TX word SHALL be {2'b00, chnnl_latched, 11'h000} in both frames; MOSI = TX bit 15 when SS_n falls.
REQ-019 TX register SHALL shift left on every SCLK fall (11111->00000) except the first fall of a frame (15 shifts/frame).
REQ-020 MISO SHALL be sampled into a 16-bit RX shift register (LSB in) on each SCLK rise.
REQ-021 At FRM2 end, res SHALL load RX[11:0] (same clk cnv_cmplt sets); frame-1 RX data SHALL be discarded.
REQ-022 res SHALL hold its value until the next FRM2 end; no change at strt_cnv.
REQ-023 strt_cnv coincident with FRM2 end SHALL be ignored; a new request is accepted only from IDLE.

Reset
REQ-024 On rst_n low, asynchronously: state IDLE, a2d_SS_n=1, SCLK=1, MOSI=0, cnv_cmplt=0, res=12'h000, all counters/shift registers 0.
REQ-025 Reset mid-frame SHALL abort the conversion immediately; no partial result loaded into res.

Structure
REQ-026 Shared package SHALL hold: state enum, SCLK_DIV_LOAD=5'b10111, FRAME_BITS=16, GAP_CLKS=32.
REQ-027 A sub-module spi_mstr16 (one 16-bit frame: SS_n, SCLK, MOSI, MISO, start/done, tx/rx words) SHALL be instantiated; a2d_intf holds sequencing, latching and result.

Verification
REQ-028 Reset then idle 100 clks -> SS_n=1, SCLK=1, cnv_cmplt=0, res=0 throughout.
REQ-029 ADC model returning 12'hA5C for chnnl=3 -> MOSI word 16'h1800 both frames; cnv_cmplt rises exactly 1073 clks after strt_cnv; res=12'hA5C.
REQ-030 Sweep chnnl 0-7, model returns {9'h0,chnnl} -> res matches per channel; 32 SCLK rises per conversion, each frame SS_n low exactly 520 clks.
REQ-031 strt_cnv repulsed at cycles 10 and 600 of a conversion -> ignored; one conversion completes at cycle 1073, chnnl change at cycle 10 not used.
REQ-032 rst_n pulsed low at cycle 300 of a conversion with prior res=12'h123 -> res=0, SS_n=1, SCLK=1 immediately; next strt_cnv runs a full clean conversion.
REQ-033 Back-to-back: strt_cnv the cycle after cnv_cmplt rises -> cnv_cmplt clears next clk, res keeps old value until new FRM2 end.

Source files
------------

// File: rtl/a2d_intf_pkg.sv
// Shared types and constants for the A2D SPI conversion interface.
package a2d_intf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FRM1 = 2'd1,
    GAP  = 2'd2,
    FRM2 = 2'd3
  } state_t;

  localparam logic [4:0] SCLK_DIV_LOAD = 5'b10111;
  localparam logic [4:0] SCLK_DIV_END  = 5'b11110;
  localparam int         FRAME_BITS    = 16;
  localparam int         GAP_CLKS      = 32;

  // Command word sent to the ADC: channel sits in bits [13:11].
  function automatic logic [15:0] a2d_cmd(input logic [2:0] chnnl);
    return {2'b00, chnnl, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_intf_if.sv
// Host request/result signals plus the SPI pins of the A2D interface.
interface a2d_intf_if;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        a2d_SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  modport slave (
    input  strt_cnv, chnnl, MISO,
    output cnv_cmplt, res, a2d_SS_n, SCLK, MOSI
  );

  modport master (
    output strt_cnv, chnnl, MISO,
    input  cnv_cmplt, res, a2d_SS_n, SCLK, MOSI
  );
endinterface

// File: rtl/a2d_intf_spi_mstr16.sv
// Single 16-bit SPI frame engine: SCLK = clk/32 from a 5-bit divider, idle high,
// MOSI shifted on falling SCLK, MISO captured on rising SCLK.
module spi_mstr16
  import a2d_intf_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] tx_word,
  output logic        done,
  output logic [15:0] rx_word,
  output logic        ss_n,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  logic        ss_n_q;
  logic [4:0]  div;
  logic [4:0]  rise_cnt;
  logic [15:0] tx_sh;
  logic [15:0] rx_sh;
  logic        active;
  logic        rise_now;
  logic        fall_now;

  assign active   = ~ss_n_q;
  assign rise_now = active && (div == 5'b01111);
  assign fall_now = active && (div == 5'b11111);
  // Frame ends once all bits are clocked and SCLK has sat high for the tail.
  assign done     = active && (rise_cnt == 5'(FRAME_BITS)) && (div == SCLK_DIV_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_q   <= 1'b1;
      div      <= '0;
      rise_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
    end else if (start && !active) begin
      ss_n_q   <= 1'b0;
      div      <= SCLK_DIV_LOAD;
      rise_cnt <= '0;
      tx_sh    <= tx_word;
    end else if (active) begin
      if (done) ss_n_q <= 1'b1;
      else      div    <= div + 5'd1;
      if (rise_now) begin
        rx_sh    <= {rx_sh[14:0], miso};
        rise_cnt <= rise_cnt + 5'd1;
      end
      // The first fall precedes any rise, so bit 15 must stay on MOSI through it.
      if (fall_now && (rise_cnt != 5'd0))
        tx_sh <= {tx_sh[14:0], 1'b0};
    end
  end

  assign ss_n    = ss_n_q;
  assign sclk    = ss_n_q | div[4];
  assign mosi    = active & tx_sh[15];
  assign rx_word = rx_sh;

endmodule

// File: rtl/a2d_intf.sv
// A2D conversion sequencer: command frame, 32-clk gap, result frame, then
// publishes the 12-bit result with cnv_cmplt.
module a2d_intf
  import a2d_intf_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  a2d_intf_if.slave     bus
);

  state_t      state, nxt_state;
  logic [2:0]  chnnl_q;
  logic [4:0]  gap_cnt;
  logic        cnv_cmplt_q;
  logic [11:0] res_q;
  logic        accept;
  logic        spi_start;
  logic        spi_done;
  logic [15:0] rx_word;
  logic [2:0]  tx_chnnl;
  logic        rx_hi_unused;

  // On the accept cycle the channel register is not yet loaded, so use the input.
  assign tx_chnnl     = (state == IDLE) ? bus.chnnl : chnnl_q;
  assign rx_hi_unused = ^rx_word[15:12];

  spi_mstr16 u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (spi_start),
    .tx_word (a2d_cmd(tx_chnnl)),
    .done    (spi_done),
    .rx_word (rx_word),
    .ss_n    (bus.a2d_SS_n),
    .sclk    (bus.SCLK),
    .mosi    (bus.MOSI),
    .miso    (bus.MISO)
  );

  always_comb begin
    nxt_state = state;
    accept    = 1'b0;
    spi_start = 1'b0;
    case (state)
      IDLE: if (bus.strt_cnv) begin
        nxt_state = FRM1;
        accept    = 1'b1;
        spi_start = 1'b1;
      end
      FRM1: if (spi_done) nxt_state = GAP;
      GAP:  if (gap_cnt == 5'(GAP_CLKS - 1)) begin
        nxt_state = FRM2;
        spi_start = 1'b1;
      end
      FRM2: if (spi_done) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      chnnl_q     <= '0;
      gap_cnt     <= '0;
      cnv_cmplt_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state   <= nxt_state;
      gap_cnt <= (state == GAP) ? gap_cnt + 5'd1 : 5'd0;
      if (accept) begin
        chnnl_q     <= bus.chnnl;
        cnv_cmplt_q <= 1'b0;
      end
      // Only the second frame carries the conversion; frame-1 data is dropped.
      if ((state == FRM2) && spi_done) begin
        res_q       <= rx_word[11:0];
        cnv_cmplt_q <= 1'b1;
      end
    end
  end

  assign bus.cnv_cmplt = cnv_cmplt_q;
  assign bus.res       = res_q;

endmodule

// File: tb/tb_a2d_intf.sv
// Scoreboard bench for a2d_intf with a behavioural SPI ADC model.
module tb_a2d_intf;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] res;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  a2d_intf_if bus();
  a2d_intf dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  exp_t        sb_q[$];
  logic [11:0] adc_table [8];
  logic [11:0] model_res = 12'h000;
  int          sclk_idle_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ADC model: frame 1 carries the channel command, frame 2 returns that channel's sample.
  logic        prev_ss, prev_sclk;
  int          frame_cnt, rises, low_len;
  logic [15:0] mosi_w, resp;
  logic [2:0]  ch_rx, exp_ch;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ss = 1'b1; prev_sclk = 1'b1;
      frame_cnt = 0; rises = 0; low_len = 0;
      mosi_w = '0; resp = '0; ch_rx = '0; exp_ch = '0;
      bus.MISO = 1'b0;
    end else begin
      if (bus.a2d_SS_n && !bus.SCLK) sclk_idle_bad++;
      if (prev_ss && !bus.a2d_SS_n) begin
        frame_cnt++;
        rises = 0; low_len = 0; mosi_w = '0;
        chk("frm_sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        exp_ch = (sb_q.size() > 0) ? sb_q[0].ch : 3'd0;
        if (frame_cnt % 2 == 1) resp = 16'($urandom);
        else                    resp = {4'($urandom), adc_table[ch_rx]};
      end
      if (!bus.a2d_SS_n) low_len++;
      if (!prev_sclk && bus.SCLK && !bus.a2d_SS_n) begin
        rises++;
        mosi_w = {mosi_w[14:0], bus.MOSI};
      end
      if (!prev_ss && bus.a2d_SS_n) begin
        chk("frm_low_clks", low_len, 520);
        chk("frm_rises", rises, 16);
        chk("frm_mosi", {16'h0, mosi_w}, {16'h0, 2'b00, exp_ch, 11'h000});
        if (frame_cnt % 2 == 1) ch_rx = mosi_w[13:11];
      end
      bus.MISO = (!bus.a2d_SS_n && rises < 16) ? resp[4'(15 - rises)] : 1'b0;
      prev_ss   = bus.a2d_SS_n;
      prev_sclk = bus.SCLK;
    end
  end

  // Result monitor: every rising cnv_cmplt retires the oldest expected conversion.
  logic prev_cc = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) prev_cc = 1'b0;
    else begin
      if (bus.cnv_cmplt && !prev_cc) begin
        chk("cmplt_expected", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("res", {20'h0, bus.res}, {20'h0, e.res});
          chk("latency", cyc - e.acc, 1073);
        end
      end
      prev_cc = bus.cnv_cmplt;
    end
  end

  task automatic run_conv(input logic [2:0] ch, input bit poke);
    exp_t        e;
    int          n;
    logic [11:0] prev_res;
    prev_res = model_res;
    e.ch = ch; e.res = adc_table[ch]; e.acc = cyc;
    sb_q.push_back(e);
    bus.strt_cnv = 1'b1;
    bus.chnnl    = ch;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.strt_cnv = poke && (n == 10 || n == 600 || n == 1072);
      bus.chnnl    = 3'($urandom);
      if (n == 1) begin
        chk("cmplt_clr", {31'h0, bus.cnv_cmplt}, 32'd0);
        chk("res_hold_start", {20'h0, bus.res}, {20'h0, prev_res});
      end
      if (n == 1072) chk("res_hold_end", {20'h0, bus.res}, {20'h0, prev_res});
    end while (!bus.cnv_cmplt && n < 1200);
    bus.strt_cnv = 1'b0;
    chk("cmplt_cycle", n, 1073);
    model_res = e.res;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.strt_cnv = 1'b0;
    bus.chnnl    = 3'd0;
    rst_n        = 1'b0;
    for (int i = 0; i < 8; i++) adc_table[i] = 12'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_state", {17'h0, bus.a2d_SS_n, bus.SCLK, bus.MOSI, bus.cnv_cmplt, bus.res},
        {17'h0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000});
    rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      chk("idle", {18'h0, bus.a2d_SS_n, bus.SCLK, bus.cnv_cmplt, bus.res},
          {18'h0, 1'b1, 1'b1, 1'b0, 12'h000});
    end

    adc_table[3] = 12'hA5C;
    run_conv(3'd3, 1'b0);
    chk("res_A5C", {20'h0, bus.res}, 32'h0000_0A5C);

    for (int ch = 0; ch < 8; ch++) begin
      adc_table[ch] = {9'h0, 3'(ch)};
      repeat ($urandom_range(1, 20)) @(negedge clk);
      run_conv(3'(ch), 1'b0);
    end

    adc_table[5] = 12'($urandom);
    repeat (5) @(negedge clk);
    run_conv(3'd5, 1'b1);
    repeat (40) @(negedge clk);
    chk("no_restart", {30'h0, bus.a2d_SS_n, bus.cnv_cmplt}, 32'd3);
    chk("sb_drained", sb_q.size(), 0);

    adc_table[2] = 12'($urandom);
    adc_table[6] = 12'($urandom);
    run_conv(3'd2, 1'b0);
    run_conv(3'd6, 1'b0);

    repeat (4) begin
      logic [2:0] ch;
      ch = 3'($urandom);
      adc_table[ch] = 12'($urandom);
      repeat ($urandom_range(1, 30)) @(negedge clk);
      run_conv(ch, 1'b0);
    end

    adc_table[1] = 12'h123;
    repeat (3) @(negedge clk);
    run_conv(3'd1, 1'b0);
    chk("res_123", {20'h0, bus.res}, 32'h0000_0123);
    begin
      exp_t e;
      e.ch = 3'd4; e.res = adc_table[4]; e.acc = cyc;
      sb_q.push_back(e);
    end
    bus.strt_cnv = 1'b1;
    bus.chnnl    = 3'd4;
    @(negedge clk);
    bus.strt_cnv = 1'b0;
    repeat (299) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("abort", {18'h0, bus.a2d_SS_n, bus.SCLK, bus.cnv_cmplt, bus.res},
           {18'h0, 1'b1, 1'b1, 1'b0, 12'h000});
    sb_q.delete();
    model_res = 12'h000;
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    adc_table[4] = 12'($urandom);
    run_conv(3'd4, 1'b0);

    repeat (10) @(negedge clk);
    chk("sclk_high_when_ss_high", sclk_idle_bad, 0);
    chk("sb_final_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
